// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: FSM encoding, BCD limits and the {hour,min} payload.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } alarm_state_t;

  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
  } bcd_hm_t;

  // True when both bytes are well-formed BCD and inside the 00:00..23:59 range.
  function automatic logic bcd_hm_valid(input logic [7:0] hour, input logic [7:0] min);
    return (hour[3:0] <= 4'd9) && (hour[7:4] <= 4'd9) && (hour <= BCD_MAX_HOUR) &&
           (min[3:0]  <= 4'd9) && (min[7:4]  <= 4'd9) && (min  <= BCD_MAX_MIN);
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Bus between the alarm sequencer and its surroundings (time chain, keypad, LED bank).
interface alarm_ring_ctrl_if;
  import clock_pkg::*;

  logic         tick_1hz;
  logic         alarm_en;
  logic         set_load;
  logic [7:0]   set_hour;
  logic [7:0]   set_min;
  logic [7:0]   cur_hour;
  logic [7:0]   cur_min;
  logic [7:0]   cur_sec;
  logic         snooze_btn;
  logic         stop_btn;
  logic         ringing;
  logic         beep;
  logic [15:0]  led;
  bcd_hm_t      alarm_time;
  bcd_hm_t      next_time;
  logic [2:0]   snooze_cnt;
  alarm_state_t state;

  modport master (
    output tick_1hz, alarm_en, set_load, set_hour, set_min,
           cur_hour, cur_min, cur_sec, snooze_btn, stop_btn,
    input  ringing, beep, led, alarm_time, next_time, snooze_cnt, state
  );

  modport slave (
    input  tick_1hz, alarm_en, set_load, set_hour, set_min,
           cur_hour, cur_min, cur_sec, snooze_btn, stop_btn,
    output ringing, beep, led, alarm_time, next_time, snooze_cnt, state
  );

endinterface

// File: rtl/bcd_time_add.sv
// Combinational {hour,min} BCD plus 0..59 minutes, wrapping 23:59 -> 00:00.
module bcd_time_add
  import clock_pkg::*;
(
  input  bcd_hm_t    base,
  input  logic [5:0] add_min,
  output bcd_hm_t    sum
);

  logic [6:0] min_bin;
  logic [4:0] hour_bin;
  logic       carry;

  always_comb begin
    min_bin  = 7'(base.min[7:4]) * 7'd10 + 7'(base.min[3:0]) + 7'(add_min);
    carry    = (min_bin >= 7'd60);
    if (carry) min_bin = min_bin - 7'd60;
    hour_bin = 5'(base.hour[7:4]) * 5'd10 + 5'(base.hour[3:0]) + 5'(carry);
    if (hour_bin >= 5'd24) hour_bin = hour_bin - 5'd24;
    sum.min  = {4'(min_bin / 7'd10), 4'(min_bin % 7'd10)};
    sum.hour = {4'(hour_bin / 5'd10), 4'(hour_bin % 5'd10)};
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: holds alarm/next trigger time, runs RING/SNOOZE/dismiss, drives chaser and buzzer.
module alarm_ring_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned RING_SEC   = 60
) (
  input logic              CP,
  input logic              CR,
  alarm_ring_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SNZ_W = 3;

  alarm_state_t     state_q, state_n;
  logic [15:0]      led_q, led_n;
  logic             beep_q, beep_n;
  logic             ringing_q, ringing_n;
  bcd_hm_t          alarm_q, alarm_n;
  bcd_hm_t          next_q, next_n;
  logic [SNZ_W-1:0] snz_q, snz_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  bcd_hm_t cur_hm;
  bcd_hm_t snooze_time;
  logic    load_ok;
  logic    trigger;

  assign cur_hm = '{hour: bus.cur_hour, min: bus.cur_min};

  bcd_time_add u_snooze_add (
    .base    (cur_hm),
    .add_min (6'(SNOOZE_MIN)),
    .sum     (snooze_time)
  );

  always_ff @(posedge CP) begin
    if (CR) begin
      state_q   <= ST_IDLE;
      led_q     <= '0;
      beep_q    <= 1'b0;
      ringing_q <= 1'b0;
      alarm_q   <= '0;
      next_q    <= '0;
      snz_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_n;
      led_q     <= led_n;
      beep_q    <= beep_n;
      ringing_q <= ringing_n;
      alarm_q   <= alarm_n;
      next_q    <= next_n;
      snz_q     <= snz_n;
      cnt_q     <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    led_n   = led_q;
    beep_n  = beep_q;
    next_n  = next_q;
    snz_n   = snz_q;
    cnt_n   = cnt_q;

    load_ok = bus.set_load && bcd_hm_valid(bus.set_hour, bus.set_min);
    alarm_n = load_ok ? bcd_hm_t'({bus.set_hour, bus.set_min}) : alarm_q;
    trigger = bus.tick_1hz && (cur_hm == next_q) && (bus.cur_sec == 8'h00);

    if (!bus.alarm_en) begin
      state_n = ST_IDLE;
      led_n   = '0;
      beep_n  = 1'b0;
      snz_n   = '0;
      cnt_n   = '0;
      next_n  = alarm_n;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_n = ST_ARMED;
          if (load_ok) next_n = alarm_n;
        end
        ST_ARMED, ST_SNOOZE: begin
          // A fresh load re-arms and suppresses a same-cycle trigger.
          if (load_ok) begin
            state_n = ST_ARMED;
            next_n  = alarm_n;
            snz_n   = '0;
          end else if (trigger) begin
            state_n = ST_RING;
            led_n   = 16'h0001;
            beep_n  = 1'b1;
            cnt_n   = '0;
          end
        end
        ST_RING: begin
          // Buttons take precedence over the tick (and over ring expiry).
          if (bus.stop_btn) begin
            state_n = ST_ARMED;
            next_n  = alarm_n;
            snz_n   = '0;
            led_n   = '0;
            beep_n  = 1'b0;
            cnt_n   = '0;
          end else if (bus.snooze_btn && (snz_q < SNZ_W'(MAX_SNOOZE))) begin
            state_n = ST_SNOOZE;
            next_n  = snooze_time;
            snz_n   = snz_q + SNZ_W'(1);
            led_n   = '0;
            beep_n  = 1'b0;
            cnt_n   = '0;
          end else if (bus.tick_1hz) begin
            if (cnt_q == CNT_W'(RING_SEC - 1)) begin
              state_n = ST_ARMED;
              next_n  = alarm_n;
              snz_n   = '0;
              led_n   = '0;
              beep_n  = 1'b0;
              cnt_n   = '0;
            end else begin
              led_n  = {led_q[14:0], led_q[15]};
              beep_n = ~beep_q;
              cnt_n  = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    ringing_n = (state_n == ST_RING);
  end

  assign bus.state      = state_q;
  assign bus.led        = led_q;
  assign bus.beep       = beep_q;
  assign bus.ringing    = ringing_q;
  assign bus.alarm_time = alarm_q;
  assign bus.next_time  = next_q;
  assign bus.snooze_cnt = snz_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: minutes-of-day reference model checked every cycle plus literal pins.
module tb_alarm_ring_ctrl;

  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;
  localparam int RING_SEC   = 60;

  logic CP = 1'b0;
  logic CR = 1'b1;
  always #5 CP = ~CP;

  alarm_ring_ctrl_if bus ();

  alarm_ring_ctrl #(
    .SNOOZE_MIN (SNOOZE_MIN),
    .MAX_SNOOZE (MAX_SNOOZE),
    .RING_SEC   (RING_SEC)
  ) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: times kept as minutes since midnight; led/beep derived from ticks spent ringing.
  int m_state = 0;
  int m_alarm = 0;
  int m_next  = 0;
  int m_snz   = 0;
  int m_ticks = 0;

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] hm_bcd(input int mins);
    return {bcd8(mins / 60), bcd8(mins % 60)};
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit load_valid(input logic [7:0] h, input logic [7:0] m);
    if (h[3:0] > 4'd9 || h[7:4] > 4'd9 || m[3:0] > 4'd9 || m[7:4] > 4'd9) return 1'b0;
    return (bcd_val(h) < 24) && (bcd_val(m) < 60);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic dismiss();
    m_state = 1;
    m_next  = m_alarm;
    m_snz   = 0;
  endtask

  always @(posedge CP) begin : model
    int  cur_m;
    bit  vld;
    int  new_m;
    cur_m = bcd_val(bus.cur_hour) * 60 + bcd_val(bus.cur_min);
    vld   = bus.set_load && load_valid(bus.set_hour, bus.set_min);
    new_m = bcd_val(bus.set_hour) * 60 + bcd_val(bus.set_min);
    if (CR) begin
      m_state = 0; m_alarm = 0; m_next = 0; m_snz = 0; m_ticks = 0;
    end else begin
      if (vld) m_alarm = new_m;
      if (!bus.alarm_en) begin
        m_state = 0; m_snz = 0; m_next = m_alarm;
      end else if (m_state == 0) begin
        m_state = 1;
        if (vld) m_next = new_m;
      end else if (m_state == 1 || m_state == 3) begin
        if (vld) begin
          m_state = 1; m_next = new_m; m_snz = 0;
        end else if (bus.tick_1hz && cur_m == m_next && bus.cur_sec == 8'h00) begin
          m_state = 2; m_ticks = 0;
        end
      end else begin
        if (bus.stop_btn) dismiss();
        else if (bus.snooze_btn && m_snz < MAX_SNOOZE) begin
          m_state = 3; m_snz++; m_next = (cur_m + SNOOZE_MIN) % 1440;
        end else if (bus.tick_1hz) begin
          m_ticks++;
          if (m_ticks == RING_SEC) dismiss();
        end
      end
    end
  end

  always @(negedge CP) begin
    if (cmp_en) begin
      chk("state",      32'(bus.state), 32'(m_state));
      chk("ringing",    32'(bus.ringing), 32'(m_state == 2));
      chk("beep",       32'(bus.beep), 32'(m_state == 2 && (m_ticks % 2) == 0));
      chk("led",        32'(bus.led), (m_state == 2) ? (32'd1 << (m_ticks % 16)) : 32'd0);
      chk("alarm_time", 32'(bus.alarm_time), 32'(hm_bcd(m_alarm)));
      chk("next_time",  32'(bus.next_time), 32'(hm_bcd(m_next)));
      chk("snooze_cnt", 32'(bus.snooze_cnt), 32'(m_snz));
    end
  end

  task automatic cyc();
    @(posedge CP);
    #1;
    bus.tick_1hz   = 1'b0;
    bus.set_load   = 1'b0;
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hour = bcd8(h);
    bus.cur_min  = bcd8(m);
    bus.cur_sec  = bcd8(s);
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m);
    bus.set_load = 1'b1;
    bus.set_hour = h;
    bus.set_min  = m;
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    set_cur(h, m, s);
    bus.tick_1hz = 1'b1;
    cyc();
  endtask

  initial begin
    // Reset with random inputs on every bus line.
    for (int i = 0; i < 3; i++) begin
      bus.tick_1hz   = 1'($urandom);
      bus.alarm_en   = 1'($urandom);
      bus.set_load   = 1'($urandom);
      bus.set_hour   = 8'($urandom);
      bus.set_min    = 8'($urandom);
      bus.cur_hour   = 8'($urandom);
      bus.cur_min    = 8'($urandom);
      bus.cur_sec    = 8'($urandom);
      bus.snooze_btn = 1'($urandom);
      bus.stop_btn   = 1'($urandom);
      cyc();
      cmp_en = 1'b1;
    end
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_alarm", 32'(bus.alarm_time), 32'h0000);
    chk("rst_led",   32'(bus.led), 32'h0000);
    chk("rst_beep",  32'(bus.beep), 32'd0);

    CR = 1'b0;
    bus.alarm_en = 1'b0;
    set_cur(7, 29, 59);

    load(8'h07, 8'h30); cyc();
    chk("load_alarm", 32'(bus.alarm_time), 32'h0730);
    chk("load_next",  32'(bus.next_time), 32'h0730);
    bus.alarm_en = 1'b1; cyc();
    chk("armed", 32'(bus.state), 32'd1);

    tick_at(7, 30, 1);
    chk("no_trig_sec1", 32'(bus.ringing), 32'd0);
    tick_at(7, 30, 0);
    chk("trig_ring", 32'(bus.ringing), 32'd1);
    chk("trig_led",  32'(bus.led), 32'h0001);
    for (int i = 1; i <= 3; i++) tick_at(7, 30, i);
    chk("chase_led", 32'(bus.led), 32'h0008);

    bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1; cyc();
    chk("stop_wins_state", 32'(bus.state), 32'd1);
    chk("stop_wins_snz",   32'(bus.snooze_cnt), 32'd0);

    // Snooze chain across midnight.
    load(8'h23, 8'h58); cyc();
    tick_at(23, 58, 0);
    bus.snooze_btn = 1'b1; cyc();
    chk("snz_wrap_next", 32'(bus.next_time), 32'h0003);
    chk("snz_wrap_cnt",  32'(bus.snooze_cnt), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      int t;
      t = (23 * 60 + 58 + SNOOZE_MIN * k) % 1440;
      tick_at(t / 60, t % 60, 0);
      bus.snooze_btn = 1'b1; cyc();
    end
    chk("snz_max_ring", 32'(bus.state), 32'd2);
    chk("snz_max_cnt",  32'(bus.snooze_cnt), 32'd3);

    for (int i = 1; i < RING_SEC; i++) tick_at(0, 13, i % 60);
    chk("pre_expire", 32'(bus.state), 32'd2);
    tick_at(0, 14, 0);
    chk("auto_dis_state", 32'(bus.state), 32'd1);
    chk("auto_dis_led",   32'(bus.led), 32'h0000);
    chk("auto_dis_next",  32'(bus.next_time), 32'h2358);

    load(8'h24, 8'h00); cyc();
    chk("bad_hour", 32'(bus.alarm_time), 32'h2358);
    load(8'h12, 8'h5A); cyc();
    chk("bad_min", 32'(bus.alarm_time), 32'h2358);
    load(8'h1A, 8'h00); cyc();

    tick_at(23, 58, 0);
    load(8'h06, 8'h15); cyc();
    chk("ring_load_alarm", 32'(bus.alarm_time), 32'h0615);
    chk("ring_load_next",  32'(bus.next_time), 32'h2358);
    bus.stop_btn = 1'b1; cyc();
    chk("stop_apply_next", 32'(bus.next_time), 32'h0615);

    load(8'h07, 8'h00); tick_at(6, 15, 0);
    chk("load_vs_trig", 32'(bus.state), 32'd1);

    // Snooze press in the same cycle as ring expiry.
    tick_at(7, 0, 0);
    for (int i = 1; i < RING_SEC; i++) tick_at(7, 0, i);
    bus.snooze_btn = 1'b1; tick_at(7, 1, 0);
    chk("btn_at_expiry", 32'(bus.state), 32'd3);
    chk("btn_expiry_next", 32'(bus.next_time), 32'h0706);

    load(8'h07, 8'h00); cyc();
    chk("snooze_load", 32'(bus.state), 32'd1);

    tick_at(7, 0, 0);
    tick_at(7, 0, 1);
    bus.alarm_en = 1'b0; cyc();
    chk("en_drop_state", 32'(bus.state), 32'd0);
    chk("en_drop_led",   32'(bus.led), 32'h0000);
    cyc();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
